// File: rtl/mmio_uart_tx_if.sv
// mmio_uart_tx_if: CPU data-bus view of a memory-mapped peripheral.
//   AddressBus  CPU effective address
//   DataBusOut  CPU store data
//   ControlBus  {MemWriteEn, MemReadEn, RegWriteEn}
//   DataBusIn   load data returned by the peripheral (0 when not selected)
//   hit         peripheral claims the current access
// master = CPU side, slave = peripheral side.
interface mmio_uart_tx_if;
    logic [63:0] AddressBus;
    logic [63:0] DataBusOut;
    logic [2:0]  ControlBus;
    logic [63:0] DataBusIn;
    logic        hit;

    modport master (
        output AddressBus,
        output DataBusOut,
        output ControlBus,
        input  DataBusIn,
        input  hit
    );

    modport slave (
        input  AddressBus,
        input  DataBusOut,
        input  ControlBus,
        output DataBusIn,
        output hit
    );
endinterface

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a small TX FIFO.
//   clk   system clock, all state on posedge
//   rst   asynchronous active-low reset
//   bus   CPU data bus (slave): TXDATA at window offset 0x0, STATUS at 0x8
//   tx    registered serial output, idle high
// STATUS: bit0 full, bit1 empty, bit2 busy, bit3 overflow (sticky, cleared by
// any STATUS write), bits[15:8] FIFO count.
module mmio_uart_tx #(
    parameter logic [63:0] BASE_ADDR    = 64'h0000_0000_0001_0000,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic               clk,
    input  logic               rst,
    mmio_uart_tx_if.slave      bus,
    output logic               tx
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_TOP = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    // Bus decode
    logic sel_c, we_c, re_c, reg_c;
    logic push_c, clr_ovf_c;
    assign sel_c     = (bus.AddressBus[63:4] == BASE_ADDR[63:4]);
    assign we_c      = bus.ControlBus[2];
    assign re_c      = bus.ControlBus[1];
    assign reg_c     = bus.AddressBus[3];
    assign push_c    = sel_c & we_c & ~reg_c;
    assign clr_ovf_c = sel_c & we_c & reg_c;

    // Address low bits, upper store data and RegWriteEn carry no meaning here
    logic unused_bits;
    assign unused_bits = ^{bus.AddressBus[2:0], bus.DataBusOut[63:8], bus.ControlBus[0]};

    // FIFO state
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q;
    logic          full_c, empty_c, accept_c, pop_c;

    // Transmit FSM state
    state_e        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;

    assign full_c   = (count_q == DEPTH_C);
    assign empty_c  = (count_q == '0);
    // A full FIFO still takes a byte when the FSM pops in the same cycle
    assign accept_c = push_c & (~full_c | pop_c);

    // Status register and load data (combinational, same-cycle read)
    logic [63:0] status_c;
    assign status_c = {48'h0, 8'(count_q), 4'h0, ovf_q, (state_q != IDLE), empty_c, full_c};
    assign bus.DataBusIn = (sel_c & re_c & reg_c) ? status_c : 64'h0;
    assign bus.hit       = sel_c & (we_c | re_c);
    assign tx            = tx_q;

    // FIFO occupancy update
    always_comb begin
        count_d = count_q;
        case ({accept_c, pop_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (accept_c) begin
            mem_q[wr_ptr_q] <= bus.DataBusOut[7:0];
        end
    end

    // FIFO pointers, count and sticky overflow
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            if (accept_c) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push_c & full_c & ~pop_c) begin
                ovf_q <= 1'b1;
            end else if (clr_ovf_c) begin
                ovf_q <= 1'b0;
            end
        end
    end

    // Transmit FSM: state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    // Transmit FSM: next state; tx_d is the level for the coming bit period
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty_c) begin
                    pop_c   = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    tx_d    = 1'b0;
                    baud_d  = BAUD_TOP;
                    state_d = START;
                end
            end
            START: begin
                if (baud_q == '0) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                    baud_d  = BAUD_TOP;
                    bit_d   = 3'd0;
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end
            DATA: begin
                if (baud_q == '0) begin
                    baud_d = BAUD_TOP;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end
            STOP: begin
                if (baud_q == '0) begin
                    // Chain straight into the next start bit when data is waiting
                    if (!empty_c) begin
                        pop_c   = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        tx_d    = 1'b0;
                        baud_d  = BAUD_TOP;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter on the CPU data bus, downstream of the single-cycle core. Decodes the core's address/control bus, accepts byte stores into a small TX FIFO, and serialises bytes as 8N1 frames on `tx`. Exposes a status register for polling through loads. Gives programs a console output path alongside the `ecall` halt mechanism.

## Interface
Parameters:
- `BASE_ADDR`, 64'h0000_0000_0001_0000: base of the 16-byte register window; bits [3:0] must be 0.
- `CLKS_PER_BIT`, 16: clock cycles per serial bit, ≥2.
- `FIFO_DEPTH`, 8: TX FIFO entries; a power of 2, ≥2.

Ports:
- `clk`  in  1  system clock; all state updates on posedge.
- `rst`  in  1  asynchronous, active-low reset.
- `AddressBus`  in  64  CPU effective address.
- `DataBusOut`  in  64  CPU store data; only [7:0] is used.
- `ControlBus`  in  3  {MemWriteEn, MemReadEn, RegWriteEn}; RegWriteEn is ignored.
- `DataBusIn`  out  64  load data returned to the CPU; 0 when not selected.
- `hit`  out  1  address is in the window and MemReadEn or MemWriteEn is set; drives the system read-data mux.
- `tx`  out  1  serial output, idle high.

## Operation
- Decode: `sel` = (AddressBus[63:4] == BASE_ADDR[63:4]). AddressBus[3] selects the register: 0 = TXDATA, 1 = STATUS. Bits [2:0] are ignored.
- TXDATA write (sel, MemWriteEn, A[3]=0): pushes DataBusOut[7:0] at posedge. A TXDATA read returns 0.
- STATUS read is combinational, same cycle, matching the single-cycle core:
  - bit0 full
  - bit1 empty
  - bit2 busy (FSM not IDLE)
  - bit3 overflow (sticky)
  - bits[15:8] FIFO count (zero-extended)
  - all other bits 0
- STATUS write (any data): clears overflow.
- Push while full with no pop in the same cycle: byte dropped, overflow set. Push while full with a pop in the same cycle: byte accepted, count unchanged.
- FIFO: circular buffer with read/write pointers that wrap at FIFO_DEPTH, and a count register of width $clog2(FIFO_DEPTH)+1.
- FSM states: IDLE, START, DATA, STOP.
  - Bit counter: 0..7. Baud counter: CLKS_PER_BIT-1 down to 0.
  - IDLE → START when the FIFO is non-empty. The FSM pops the head into the shift register and tx goes 0.
  - START → DATA when the baud counter reaches 0. tx = shift[0].
  - DATA: on each baud expiry, shift right and increment the bit counter. After bit 7 expires → STOP, tx = 1.
  - STOP on expiry: if the FIFO is non-empty, pop and go to START directly, with no idle gap. Otherwise go to IDLE.
  - Bits go out LSB first.

## Timing
- Reset values (asserted asynchronously):
  - tx = 1
  - state = IDLE
  - FIFO empty: pointers 0, count 0
  - overflow = 0
  - baud and bit counters = 0
  - DataBusIn and hit are combinational from the bus, so they show a STATUS read of the reset state.
- tx is a registered output.
- Write-to-wire latency: a push at edge N into an empty FIFO with the FSM IDLE gives the pop and tx = 0 at edge N+1.
- Each bit is held exactly CLKS_PER_BIT cycles. A frame lasts 10·CLKS_PER_BIT cycles. Back-to-back frames are contiguous.
- STATUS reflects register state before the current edge: a push at edge N shows in count after edge N.
- Simultaneous push and pop on an empty FIFO cannot occur, because a pop requires non-empty before the edge.
- Reset asserted mid-frame forces tx = 1 immediately, discards FIFO contents, and the FSM resumes in IDLE after release.

## Test plan
Parameters for all scenarios: CLKS_PER_BIT=4, FIFO_DEPTH=4, BASE default.
- Reset, then STATUS read at 0x1_0008 → DataBusIn = 0x0000_0000_0000_0002 (empty), hit = 1, tx = 1.
- Store 0xA5 to 0x1_0000 → tx, one cycle after the write edge, gives 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles. busy drops after 40 cycles.
- Six stores 0x01–0x06 in consecutive cycles while idle → first byte popped immediately. 0x01–0x05 are accepted (1 in the shifter + 4 in the FIFO) and 0x06 is dropped. STATUS = full|busy|overflow, count 4. Wire shows 5 contiguous frames over 200 cycles.
- STATUS write after the overflow above → bit3 = 0. Other bits unchanged.
- Non-window address 0x1_0010 with MemWriteEn → no push, hit = 0, DataBusIn = 0.
- Reset pulse 13 cycles into a frame → tx = 1 within the same cycle, STATUS = 0x2 afterwards, and no residual frame is sent.
